// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver with majority-vote sampling, break detection
// and a first-word-fall-through receive FIFO carrying per-entry error tags.
module uart_rx_fifo #(
    parameter int   CLOCK     = 12_000_000,
    parameter int   BAUD      = 9600,
    parameter int   DATABITS  = 8,
    parameter int   PARITY    = 0,
    parameter int   STOPBITS  = 1,
    parameter logic IDLELEVEL = 1'b1,
    parameter logic DATAINV   = 1'b0,
    parameter int   FIFODEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rx_pin,
    input  logic                         rd,
    input  logic                         clearerr,
    output logic [DATABITS-1:0]          data,
    output logic                         data_perr,
    output logic                         data_ferr,
    output logic                         valid,
    output logic [$clog2(FIFODEPTH):0]   count,
    output logic                         overrun,
    output logic                         framing,
    output logic                         parity_err,
    output logic                         break_det
);

    localparam int DIV_RAW = CLOCK / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW      = $clog2(FIFODEPTH);
    localparam int CW      = $clog2(FIFODEPTH) + 1;
    localparam int EW      = DATABITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRKW
    } state_t;

    state_t state;
    state_t state_nx;

    logic          s_meta;
    logic          s;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    tcnt;
    logic          t7;
    logic          t8;
    logic          t9;
    logic          t15;
    logic          v7;
    logic          v8;
    logic          maj;
    logic [3:0]    bitcnt;
    logic [DATABITS-1:0] sh;
    logic          perr_r;
    logic          ferr_r;
    logic          brk_r;
    logic          stop_last;
    logic          brk_now;
    logic          ferr_now;
    logic          frame_push;
    logic          frame_brk;

    logic [EW-1:0] mem [FIFODEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          pop;
    logic          full;
    logic          wr;
    logic          drop;

    // Two-flop synchroniser; everything downstream sees only s.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_meta <= IDLELEVEL;
            s      <= IDLELEVEL;
        end else begin
            s_meta <= rx_pin;
            s      <= s_meta;
        end
    end

    assign tick = (state != S_IDLE) && (state != S_BRKW)
                  && (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || state == S_IDLE || state == S_BRKW) begin
            div_cnt <= '0;
        end else if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state == S_IDLE || state == S_BRKW) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign t7  = tick && (tcnt == 4'd7);
    assign t8  = tick && (tcnt == 4'd8);
    assign t9  = tick && (tcnt == 4'd9);
    assign t15 = tick && (tcnt == 4'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            v7 <= IDLELEVEL;
            v8 <= IDLELEVEL;
        end else begin
            if (t7) v7 <= s;
            if (t8) v8 <= s;
        end
    end

    assign maj = (v7 & v8) | (v7 & s) | (v8 & s);

    // Bit index restarts whenever the FSM changes state.
    always_ff @(posedge clk) begin
        if (reset || state_nx != state) begin
            bitcnt <= '0;
        end else if (t15) begin
            bitcnt <= bitcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh <= '0;
        end else if (state == S_DATA && t9) begin
            sh <= {maj ^ DATAINV, sh[DATABITS-1:1]};
        end
    end

    // Per-frame error and break accumulators.
    always_ff @(posedge clk) begin
        if (reset || state == S_IDLE) begin
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            brk_r  <= 1'b1;
        end else if (t9) begin
            if (state == S_PAR) begin
                perr_r <= (PARITY == 1) ? ~(^sh ^ maj) : (^sh ^ maj);
            end
            if (state == S_STOP && maj != IDLELEVEL) begin
                ferr_r <= 1'b1;
            end
            if (state == S_DATA || state == S_PAR
                || (state == S_STOP && bitcnt == 4'd0)) begin
                brk_r <= brk_r & (maj != IDLELEVEL);
            end
        end
    end

    assign stop_last = (state == S_STOP) && t9
                       && (bitcnt == 4'(STOPBITS - 1));
    assign brk_now   = brk_r
                       && ((bitcnt == 4'd0) ? (maj != IDLELEVEL) : 1'b1);
    assign ferr_now  = ferr_r | (maj != IDLELEVEL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (s != IDLELEVEL) state_nx = S_START;
            end
            S_START: begin
                if (t9 && maj == IDLELEVEL) state_nx = S_IDLE;
                else if (t15) state_nx = S_DATA;
            end
            S_DATA: begin
                if (t15 && bitcnt == 4'(DATABITS - 1)) begin
                    state_nx = (PARITY != 0) ? S_PAR : S_STOP;
                end
            end
            S_PAR: begin
                if (t15) state_nx = S_STOP;
            end
            S_STOP: begin
                if (stop_last) state_nx = brk_now ? S_BRKW : S_IDLE;
            end
            S_BRKW: begin
                if (s == IDLELEVEL) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        frame_push = 1'b0;
        frame_brk  = 1'b0;
        if (stop_last) begin
            frame_push = !brk_now;
            frame_brk  = brk_now;
        end
    end

    assign pop  = rd && (cnt != '0);
    assign full = (cnt == CW'(FIFODEPTH));
    assign wr   = frame_push && (!full || pop);
    assign drop = frame_push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= {ferr_now, perr_r, sh};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (wr && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!wr && pop) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // A set event in the same cycle as clearerr keeps the flag high.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun    <= 1'b0;
            framing    <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            overrun    <= drop | (overrun & ~clearerr);
            framing    <= (frame_push & ferr_now) | (framing & ~clearerr);
            parity_err <= (frame_push & perr_r) | (parity_err & ~clearerr);
            break_det  <= frame_brk | (break_det & ~clearerr);
        end
    end

    assign valid     = (cnt != '0);
    assign count     = cnt;
    assign data      = valid ? mem[rptr][DATABITS-1:0] : '0;
    assign data_perr = valid ? mem[rptr][DATABITS] : 1'b0;
    assign data_ferr = valid ? mem[rptr][DATABITS+1] : 1'b0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: four configurations, directed scenarios and a
// randomized run against a queue-based reference model.
module tb_uart_rx_fifo;

    logic clk;
    logic reset;
    logic rx  [4];
    logic rd  [4];
    logic clr [4];

    logic [7:0] data0, data1, data2;
    logic [8:0] data3;
    logic [3:0] cnt0, cnt1, cnt3;
    logic [2:0] cnt2;
    logic dp0, df0, v0, ov0, fr0, pe0, bk0;
    logic dp1, df1, v1, ov1, fr1, pe1, bk1;
    logic dp2, df2, v2, ov2, fr2, pe2, bk2;
    logic dp3, df3, v3, ov3, fr3, pe3, bk3;

    int total;
    int bad;

    uart_rx_fifo #(.CLOCK(1_600_000), .BAUD(100_000)) u0 (
        .clk(clk), .reset(reset), .rx_pin(rx[0]), .rd(rd[0]),
        .clearerr(clr[0]), .data(data0), .data_perr(dp0),
        .data_ferr(df0), .valid(v0), .count(cnt0), .overrun(ov0),
        .framing(fr0), .parity_err(pe0), .break_det(bk0)
    );

    uart_rx_fifo #(.CLOCK(1_600_000), .BAUD(100_000), .PARITY(2)) u1 (
        .clk(clk), .reset(reset), .rx_pin(rx[1]), .rd(rd[1]),
        .clearerr(clr[1]), .data(data1), .data_perr(dp1),
        .data_ferr(df1), .valid(v1), .count(cnt1), .overrun(ov1),
        .framing(fr1), .parity_err(pe1), .break_det(bk1)
    );

    uart_rx_fifo #(.CLOCK(1_600_000), .BAUD(100_000), .FIFODEPTH(4)) u2 (
        .clk(clk), .reset(reset), .rx_pin(rx[2]), .rd(rd[2]),
        .clearerr(clr[2]), .data(data2), .data_perr(dp2),
        .data_ferr(df2), .valid(v2), .count(cnt2), .overrun(ov2),
        .framing(fr2), .parity_err(pe2), .break_det(bk2)
    );

    uart_rx_fifo #(
        .CLOCK(1_600_000), .BAUD(100_000), .DATABITS(9),
        .STOPBITS(2), .DATAINV(1'b1)
    ) u3 (
        .clk(clk), .reset(reset), .rx_pin(rx[3]), .rd(rd[3]),
        .clearerr(clr[3]), .data(data3), .data_perr(dp3),
        .data_ferr(df3), .valid(v3), .count(cnt3), .overrun(ov3),
        .framing(fr3), .parity_err(pe3), .break_det(bk3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] f8(input logic [7:0] d, input logic stop);
        return {6'b0, stop, d, 1'b0};
    endfunction

    // Line bits LSB first, 16 clocks each; rd pulses on clock index rd_at.
    task automatic send_line(input int inst, input logic [15:0] bits,
                             input int n, input int rd_at);
        for (int c = 0; c < n * 16; c++) begin
            rx[inst] = bits[c / 16];
            rd[inst] = (c == rd_at);
            @(negedge clk);
        end
        rd[inst] = 1'b0;
        rx[inst] = 1'b1;
    endtask

    task automatic pulse_rd(input int inst);
        rd[inst] = 1'b1;
        @(negedge clk);
        rd[inst] = 1'b0;
    endtask

    task automatic pulse_clr(input int inst);
        clr[inst] = 1'b1;
        @(negedge clk);
        clr[inst] = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({v0, ov0, fr0, pe0, bk0, dp0, df0} !== 7'd0) begin
            bad++;
            $display("FAIL reset_flags0 got=%b exp=0",
                     {v0, ov0, fr0, pe0, bk0, dp0, df0});
        end
        total++;
        if (data0 !== 8'h00 || cnt0 !== 4'd0) begin
            bad++;
            $display("FAIL reset_data0 got=%h/%0d exp=00/0", data0, cnt0);
        end
        total++;
        if ({v1, pe1, v2, ov2, cnt2, v3, data3} !== 15'd0) begin
            bad++;
            $display("FAIL reset_others got=%b exp=0",
                     {v1, pe1, v2, ov2, cnt2, v3, data3});
        end
    endtask

    task automatic test_basic;
        send_line(0, f8(8'h55, 1'b1), 10, -1);
        total++;
        if (v0 !== 1'b1 || cnt0 !== 4'd1 || data0 !== 8'h55) begin
            bad++;
            $display("FAIL basic_first got=%b/%0d/%h exp=1/1/55",
                     v0, cnt0, data0);
        end
        send_line(0, f8(8'hA3, 1'b1), 10, -1);
        total++;
        if (cnt0 !== 4'd2 || data0 !== 8'h55) begin
            bad++;
            $display("FAIL basic_two got=%0d/%h exp=2/55", cnt0, data0);
        end
        pulse_rd(0);
        total++;
        if (data0 !== 8'hA3 || cnt0 !== 4'd1) begin
            bad++;
            $display("FAIL basic_pop1 got=%h/%0d exp=a3/1", data0, cnt0);
        end
        pulse_rd(0);
        total++;
        if (v0 !== 1'b0 || cnt0 !== 4'd0) begin
            bad++;
            $display("FAIL basic_pop2 got=%b/%0d exp=0/0", v0, cnt0);
        end
        pulse_rd(0);
        total++;
        if ({v0, cnt0, ov0, fr0, pe0, bk0} !== 9'd0) begin
            bad++;
            $display("FAIL basic_flags got=%b exp=0",
                     {v0, cnt0, ov0, fr0, pe0, bk0});
        end
    endtask

    task automatic test_glitch;
        rx[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx[0] = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if ({v0, cnt0, ov0, fr0, pe0, bk0} !== 9'd0) begin
            bad++;
            $display("FAIL glitch_nopush got=%b exp=0",
                     {v0, cnt0, ov0, fr0, pe0, bk0});
        end
        send_line(0, f8(8'h3C, 1'b1), 10, -1);
        total++;
        if (cnt0 !== 4'd1 || data0 !== 8'h3C || df0 !== 1'b0) begin
            bad++;
            $display("FAIL glitch_next got=%0d/%h/%b exp=1/3c/0",
                     cnt0, data0, df0);
        end
        pulse_rd(0);
    endtask

    task automatic test_parity;
        send_line(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1);
        total++;
        if (data1 !== 8'h07 || dp1 !== 1'b1 || pe1 !== 1'b1) begin
            bad++;
            $display("FAIL parity_bad got=%h/%b/%b exp=07/1/1",
                     data1, dp1, pe1);
        end
        pulse_clr(1);
        total++;
        if (pe1 !== 1'b0 || dp1 !== 1'b1 || df1 !== 1'b0) begin
            bad++;
            $display("FAIL parity_clr got=%b/%b/%b exp=0/1/0", pe1, dp1, df1);
        end
        pulse_rd(1);
        send_line(1, {5'b0, 1'b1, 1'b0, 8'h0F, 1'b0}, 11, -1);
        total++;
        if (data1 !== 8'h0F || dp1 !== 1'b0 || pe1 !== 1'b0) begin
            bad++;
            $display("FAIL parity_good got=%h/%b/%b exp=0f/0/0",
                     data1, dp1, pe1);
        end
        pulse_rd(1);
    endtask

    task automatic test_frame_break;
        send_line(0, f8(8'h81, 1'b0), 10, -1);
        repeat (32) @(negedge clk);
        total++;
        if (data0 !== 8'h81 || df0 !== 1'b1 || fr0 !== 1'b1) begin
            bad++;
            $display("FAIL ferr_tag got=%h/%b/%b exp=81/1/1", data0, df0, fr0);
        end
        total++;
        if (cnt0 !== 4'd1 || bk0 !== 1'b0) begin
            bad++;
            $display("FAIL ferr_nobreak got=%0d/%b exp=1/0", cnt0, bk0);
        end
        rx[0] = 1'b0;
        repeat (320) @(negedge clk);
        rx[0] = 1'b1;
        repeat (32) @(negedge clk);
        total++;
        if (bk0 !== 1'b1 || cnt0 !== 4'd1) begin
            bad++;
            $display("FAIL break_det got=%b/%0d exp=1/1", bk0, cnt0);
        end
        send_line(0, f8(8'h5A, 1'b1), 10, -1);
        total++;
        if (cnt0 !== 4'd2) begin
            bad++;
            $display("FAIL break_next_cnt got=%0d exp=2", cnt0);
        end
        pulse_rd(0);
        total++;
        if (data0 !== 8'h5A || df0 !== 1'b0) begin
            bad++;
            $display("FAIL break_next got=%h/%b exp=5a/0", data0, df0);
        end
        pulse_rd(0);
        pulse_clr(0);
        total++;
        if ({fr0, bk0, ov0, pe0, v0} !== 5'd0) begin
            bad++;
            $display("FAIL break_clr got=%b exp=0", {fr0, bk0, ov0, pe0, v0});
        end
    endtask

    task automatic test_overrun;
        for (int i = 1; i <= 5; i++) begin
            send_line(2, f8(8'(i * 8'h11), 1'b1), 10, -1);
        end
        total++;
        if (cnt2 !== 3'd4 || ov2 !== 1'b1) begin
            bad++;
            $display("FAIL ovr_full got=%0d/%b exp=4/1", cnt2, ov2);
        end
        for (int i = 1; i <= 4; i++) begin
            total++;
            if (data2 !== 8'(i * 8'h11)) begin
                bad++;
                $display("FAIL ovr_order%0d got=%h exp=%h",
                         i, data2, 8'(i * 8'h11));
            end
            pulse_rd(2);
        end
        total++;
        if (v2 !== 1'b0) begin
            bad++;
            $display("FAIL ovr_lost got=%b exp=0", v2);
        end
        pulse_clr(2);
        for (int i = 1; i <= 4; i++) begin
            send_line(2, f8(8'(8'h60 + i), 1'b1), 10, -1);
        end
        send_line(2, f8(8'h65, 1'b1), 10, 156);
        total++;
        if (cnt2 !== 3'd4 || ov2 !== 1'b0 || data2 !== 8'h62) begin
            bad++;
            $display("FAIL ovr_pushpop got=%0d/%b/%h exp=4/0/62",
                     cnt2, ov2, data2);
        end
        for (int i = 2; i <= 5; i++) begin
            total++;
            if (data2 !== 8'(8'h60 + i)) begin
                bad++;
                $display("FAIL ovr_drain%0d got=%h exp=%h",
                         i, data2, 8'(8'h60 + i));
            end
            pulse_rd(2);
        end
    endtask

    task automatic test_random;
        logic [8:0] q[$];
        logic       ov_m;
        logic       fr_m;
        logic [7:0] d;
        logic       badstop;
        int         npop;
        ov_m = 1'b0;
        fr_m = 1'b0;
        for (int i = 0; i < 24; i++) begin
            d       = 8'($urandom);
            badstop = ($urandom_range(0, 5) == 0) && (d != 8'h00);
            send_line(0, f8(d, ~badstop), 10, -1);
            if (badstop) repeat (32) @(negedge clk);
            else repeat ($urandom_range(0, 20)) @(negedge clk);
            if (q.size() == 8) ov_m = 1'b1;
            else q.push_back({badstop, d});
            fr_m = fr_m | badstop;
            total++;
            if (cnt0 !== 4'(q.size()) || ov0 !== ov_m || fr0 !== fr_m) begin
                bad++;
                $display("FAIL rand_state%0d got=%0d/%b/%b exp=%0d/%b/%b",
                         i, cnt0, ov0, fr0, q.size(), ov_m, fr_m);
            end
            total++;
            if (v0 !== 1'b1 || {df0, data0} !== q[0]) begin
                bad++;
                $display("FAIL rand_head%0d got=%b/%h exp=1/%h",
                         i, v0, {df0, data0}, q[0]);
            end
            npop = $urandom_range(0, 1) + ((i % 7 == 6) ? 3 : 0);
            for (int k = 0; k < npop; k++) begin
                pulse_rd(0);
                if (q.size() > 0) void'(q.pop_front());
            end
        end
        while (q.size() > 0) begin
            total++;
            if ({df0, data0} !== q[0]) begin
                bad++;
                $display("FAIL rand_drain got=%h exp=%h", {df0, data0}, q[0]);
            end
            pulse_rd(0);
            void'(q.pop_front());
        end
        total++;
        if (v0 !== 1'b0 || cnt0 !== 4'd0) begin
            bad++;
            $display("FAIL rand_empty got=%b/%0d exp=0/0", v0, cnt0);
        end
    endtask

    task automatic test_wide_reset;
        logic [8:0] d;
        d = 9'h1A5;
        send_line(3, {4'b0, 2'b11, ~d, 1'b0}, 12, -1);
        total++;
        if (data3 !== 9'h1A5 || cnt3 !== 4'd1 || {df3, fr3} !== 2'b00) begin
            bad++;
            $display("FAIL wide_data got=%h/%0d/%b exp=1a5/1/00",
                     data3, cnt3, {df3, fr3});
        end
        d = 9'h0C3;
        send_line(3, {4'b0, 2'b11, ~d, 1'b0}, 4, -1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        total++;
        if ({v3, cnt3, ov3, fr3, pe3, bk3} !== 9'd0) begin
            bad++;
            $display("FAIL wide_reset got=%b exp=0",
                     {v3, cnt3, ov3, fr3, pe3, bk3});
        end
        d = 9'h0C3;
        send_line(3, {4'b0, 2'b11, ~d, 1'b0}, 12, -1);
        total++;
        if (data3 !== 9'h0C3 || cnt3 !== 4'd1 || fr3 !== 1'b0) begin
            bad++;
            $display("FAIL wide_after got=%h/%0d/%b exp=0c3/1/0",
                     data3, cnt3, fr3);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx[i]  = 1'b1;
            rd[i]  = 1'b0;
            clr[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_parity();
        test_frame_break();
        test_overrun();
        test_random();
        test_wide_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised asynchronous serial receiver and the next generation of the team's 16x-oversampled receiver.
- Adds configurable data width, parity and stop-bit count.
- Adds majority-vote sampling, break detection and a first-word-fall-through receive FIFO with per-entry error tags.
- Sits between an external RX pin and any host-side consumer, such as a CPU bus bridge or command parser.

Parameters:
CLOCK, 12_000_000, system clock frequency in Hz
BAUD, 9600, line bit rate
DATABITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOPBITS, 1, stop bits checked; legal 1 or 2
IDLELEVEL, 1'b1, line level when idle
DATAINV, 1'b0, 1 = data bits inverted on the line
FIFODEPTH, 8, receive FIFO entries; power of 2, 2..16

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_pin  in  1  asynchronous serial input
rd  in  1  pop FIFO head (ignored when empty)
clearerr  in  1  clear sticky flags
data  out  DATABITS  FIFO head data (valid only when valid=1)
data_perr  out  1  parity-error tag of FIFO head
data_ferr  out  1  framing-error tag of FIFO head
valid  out  1  FIFO non-empty
count  out  $clog2(FIFODEPTH)+1  FIFO occupancy
overrun  out  1  sticky: frame dropped because FIFO full
framing  out  1  sticky: any frame with a bad stop bit
parity_err  out  1  sticky: any frame with a parity mismatch
break_det  out  1  sticky: break received

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - All outputs 0, FIFO empty, state IDLE.
  - Synchroniser and vote registers loaded with IDLELEVEL.
  - Reset mid-frame aborts the frame with no push.
- rx_pin passes a 2-FF synchroniser; all logic uses the synchronised value s.
- Tick divider:
  - DIV = CLOCK/(BAUD*16), integer truncation, minimum 1; one-cycle tick every DIV clocks.
  - Held cleared in IDLE, so the first tick comes DIV clocks after leaving IDLE.
- Sampling:
  - Each bit spans 16 ticks, numbered 0..15.
  - Bit value = majority of s at ticks 7, 8, 9, evaluated on tick 9.
  - Data bit value = majority XOR DATAINV.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when s != IDLELEVEL.
  - START: at tick 9, a majority equal to IDLELEVEL is a false start -> IDLE, no flags. Otherwise continue to DATA at tick 15.
  - DATA: DATABITS bits, LSB first, into a shift register. After the last bit -> PARITY if PARITY != 0, else STOP.
  - PARITY: compute XOR of data bits XOR the parity bit. Mismatch when the result is 0 for odd parity or 1 for even parity.
  - STOP: STOPBITS bits; each one must equal IDLELEVEL, otherwise ferr=1.
  - At tick 9 of the final stop bit, evaluate the frame and go to IDLE. A new start edge is accepted from the next clock.
- Frame completion:
  - Break = all data bits, the parity bit if present, and the first stop bit all at the non-idle line level. A break sets break_det, pushes nothing, and returns to IDLE only once s==IDLELEVEL.
  - Otherwise push {ferr, perr, data} and OR ferr/perr into framing/parity_err.
- FIFO:
  - FWFT: pushed data visible on data/valid the clock after the push.
  - rd while valid pops on that clock edge. rd while empty has no effect.
  - Push while full with no pop in the same cycle: frame discarded, overrun=1.
  - Push and pop in the same cycle when full: both occur, count unchanged, no overrun.
  - Push and pop in the same cycle when empty: the push is stored and the pop is ignored.
  - Pointers wrap modulo FIFODEPTH. count ranges 0..FIFODEPTH.
- Sticky flags:
  - Cleared by clearerr.
  - A set event in the same cycle as clearerr wins (flag = 1).

Test Plan:
CLOCK=1_600_000, BAUD=100_000 (DIV=1, 16 clocks/bit), 8N1 defaults unless stated:
1. Send 0x55 then 0xA3 -> valid rises after frame 1; data=0x55, count=2; rd -> data=0xA3; rd -> valid=0, count=0; no flags.
2. 4-clock low glitch on an idle line -> no push, state back to IDLE, all flags 0; then a normal 0x3C frame is received correctly.
3. PARITY=2 (even): send 0x07 with parity bit 0 -> entry data=0x07, data_perr=1, parity_err=1; clearerr -> parity_err=0, entry tag unchanged.
4. Send 0x81 with stop bit low -> data_ferr=1, framing=1. Then hold the line low for 20 bit times -> break_det=1, count unchanged, next frame received after the line returns idle.
5. FIFODEPTH=4: send 5 frames without rd -> count=4, overrun=1, 5th frame lost. Repeat with rd asserted on the 5th push cycle -> count=4, no overrun.
6. DATABITS=9, STOPBITS=2, DATAINV=1: send 0x1A5 -> data=0x1A5. Assert reset mid-frame -> count=0, flags 0, next frame correct.
